bus_responder: RTL and testbench

//  Single-clock bus target that answers the CPU core's address/data_out/read_en bus.

---
 rtl/bus_responder_if.sv | 11 +
 rtl/bus_responder.sv | 176 +++++++++++++++++
 tb/tb_bus_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// Core-side bus of the responder: address/data/direction from the core and
// registered read data back to the core's data_in.
interface bus_responder_if;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        read_en;
  logic [7:0]  rdata;

  modport master (output address, output wdata, output read_en, input rdata);
  modport slave  (input address, input wdata, input read_en, output rdata);
endinterface

// File: rtl/bus_responder.sv
// Bus target for the CPU core: internal RAM, reset-vector bytes and an I/O
// page with a console TX FIFO, an RX byte register, status and a cycle counter.
module bus_responder #(
  parameter int          RAM_AW     = 11,
  parameter logic [7:0]  IO_PAGE    = 8'hF0,
  parameter logic [15:0] RESET_VEC  = 16'h0200,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            ph2,
  input  logic            reset,
  bus_responder_if.slave  bus,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [7:0]    r_ram [2**RAM_AW];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [7:0]    r_rx_data;
  logic          r_rx_full;
  logic [15:0]   r_cyc;
  logic [7:0]    r_cyc_hi;
  logic [7:0]    r_rdata;

  logic          w_is_ram, w_is_vec, w_is_io;
  logic [7:0]    w_io_off;
  logic          w_rd, w_wr;
  logic          w_tx_push, w_stat_wr, w_rx_rd, w_cyclo_rd, w_ram_wr;
  logic          w_tx_full, w_tx_empty, w_pop, w_push_ok, w_drop, w_rx_cap;
  logic [7:0]    w_status;
  logic [7:0]    w_rdata_nxt;

  // Address decode in priority order: RAM, reset vector, I/O page.
  always_comb begin
    w_is_ram = 1'b0;
    w_is_vec = 1'b0;
    w_is_io  = 1'b0;
    if ((bus.address >> RAM_AW) == 16'd0) begin
      w_is_ram = 1'b1;
    end else if (bus.address[15:1] == 15'h7FFE) begin
      w_is_vec = 1'b1;
    end else if (bus.address[15:8] == IO_PAGE) begin
      w_is_io = 1'b1;
    end else begin
      w_is_io = 1'b0;
    end
  end

  assign w_io_off   = bus.address[7:0];
  assign w_rd       = bus.read_en;
  assign w_wr       = ~bus.read_en;
  assign w_ram_wr   = w_is_ram & w_wr;
  assign w_tx_push  = w_is_io & w_wr & (w_io_off == 8'h00);
  assign w_stat_wr  = w_is_io & w_wr & (w_io_off == 8'h01);
  assign w_rx_rd    = w_is_io & w_rd & (w_io_off == 8'h02);
  assign w_cyclo_rd = w_is_io & w_rd & (w_io_off == 8'h03);

  // FIFO flags come only from registered state, so tx_* never see the bus.
  assign w_tx_full  = (r_count == DEPTH_C);
  assign w_tx_empty = (r_count == {CW{1'b0}});
  assign w_pop      = ~w_tx_empty & tx_ready;
  // A push into a full FIFO is only taken if the head leaves at the same edge.
  assign w_push_ok  = w_tx_push & (~w_tx_full | w_pop);
  assign w_drop     = w_tx_push & ~w_push_ok;
  // rx_ready is low while full, so a byte offered at the clearing edge waits.
  assign w_rx_cap   = rx_valid & ~r_rx_full;

  assign tx_valid = ~w_tx_empty;
  assign tx_data  = w_tx_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign rx_ready = ~r_rx_full;
  assign bus.rdata = r_rdata;

  assign w_status = {1'b0, 3'(r_count), r_rx_full, r_ovf, w_tx_empty, w_tx_full};

  // Read data mux; unmapped space and unlisted I/O offsets read as zero.
  always_comb begin
    w_rdata_nxt = 8'h00;
    if (w_is_ram) begin
      w_rdata_nxt = r_ram[bus.address[RAM_AW-1:0]];
    end else if (w_is_vec) begin
      w_rdata_nxt = bus.address[0] ? RESET_VEC[15:8] : RESET_VEC[7:0];
    end else if (w_is_io) begin
      case (w_io_off)
        8'h01:   w_rdata_nxt = w_status;
        8'h02:   w_rdata_nxt = r_rx_data;
        8'h03:   w_rdata_nxt = r_cyc[7:0];
        8'h04:   w_rdata_nxt = r_cyc_hi;
        default: w_rdata_nxt = 8'h00;
      endcase
    end else begin
      w_rdata_nxt = 8'h00;
    end
  end

  // RAM write port; a write cut short by reset must not land.
  always_ff @(posedge ph2) begin
    if (reset && w_ram_wr) begin
      r_ram[bus.address[RAM_AW-1:0]] <= bus.wdata;
    end
  end

  // TX FIFO storage; pointers decide whether the slot becomes visible.
  always_ff @(posedge ph2) begin
    if (reset && w_push_ok) begin
      r_fifo[r_wr_ptr] <= bus.wdata;
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr && bus.wdata[2]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // RX byte register: capture when empty, RXDATA read empties it.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_rx_data <= 8'h00;
      r_rx_full <= 1'b0;
    end else if (w_rx_cap) begin
      r_rx_data <= rx_data;
      r_rx_full <= 1'b1;
    end else if (w_rx_rd) begin
      r_rx_full <= 1'b0;
    end
  end

  // Free-running cycle counter; a CYCLO read snapshots the high byte.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_cyc    <= 16'h0000;
      r_cyc_hi <= 8'h00;
    end else begin
      r_cyc <= r_cyc + 16'h0001;
      if (w_cyclo_rd) r_cyc_hi <= r_cyc[15:8];
    end
  end

  // Registered read data, held through write cycles.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      r_rdata <= 8'h00;
    end else if (w_rd) begin
      r_rdata <= w_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: read expectations and the TX byte
// stream are queued when stimulus is driven and compared as the DUT answers.
module tb_bus_responder;
  localparam int DEPTH = 4;

  logic       ph2 = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  bus_responder_if u_bus ();

  bus_responder u_dut (
    .ph2(ph2), .reset(reset), .bus(u_bus.slave),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 ph2 = ~ph2;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rd_q[$];
  string      tag_q[$];
  logic [7:0] tx_q[$];
  logic [15:0] m_cyc;

  // Reference cycle count: cleared by reset, +1 on every edge otherwise.
  always @(posedge ph2 or negedge reset) begin
    if (!reset) m_cyc <= 16'h0000;
    else        m_cyc <= m_cyc + 16'h0001;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle; checks TX head before the edge, read data after it.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rd,
                           input string tag, input logic [7:0] e);
    logic pop;
    @(negedge ph2);
    u_bus.address = a;
    u_bus.wdata   = d;
    u_bus.read_en = rd;
    if (rd && tag != "") begin
      rd_q.push_back(e);
      tag_q.push_back(tag);
    end
    #2;
    check_eq("tx_valid", 8'(tx_valid), 8'(tx_q.size() != 0));
    if (tx_q.size() != 0) check_eq("tx_data", tx_data, tx_q[0]);
    pop = (tx_q.size() != 0) && tx_ready;
    @(posedge ph2);
    #1;
    if (pop) void'(tx_q.pop_front());
    if (!rd && a == 16'hF000 && tx_q.size() < DEPTH) tx_q.push_back(d);
    if (rd_q.size() != 0) check_eq(tag_q.pop_front(), u_bus.rdata, rd_q.pop_front());
  endtask

  task automatic rd(input logic [15:0] a, input string tag, input logic [7:0] e);
    bus_cycle(a, 8'h00, 1'b1, tag, e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_cycle(a, d, 1'b0, "", 8'h00);
  endtask

  task automatic idle();
    bus_cycle(16'h9000, 8'h00, 1'b0, "", 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    u_bus.address = 16'h9000;
    u_bus.wdata   = 8'h00;
    u_bus.read_en = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge ph2);
    @(negedge ph2);
    reset = 1'b1;
    #1;
    check_eq("rst_rdata", u_bus.rdata, 8'h00);
    check_eq("rst_tx_valid", 8'(tx_valid), 8'h00);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_rx_ready", 8'(rx_ready), 8'h01);

    // Reset vector, one cycle late
    rd(16'hFFFC, "vec_lo", 8'h00);
    rd(16'hFFFD, "vec_hi", 8'h02);

    // RAM and unmapped space
    wr(16'h0123, 8'h5A);
    rd(16'h0123, "ram_rd", 8'h5A);
    rd(16'h8000, "unmapped", 8'h00);
    wr(16'h07FF, 8'h3C);
    rd(16'h0800, "ram_end", 8'h00);
    rd(16'h07FF, "ram_top", 8'h3C);
    idle();
    check_eq("rdata_hold", u_bus.rdata, 8'h3C);
    rd(16'hF010, "io_unlisted", 8'h00);
    rd(16'hF000, "txdata_rd", 8'h00);

    // Overfill the TX FIFO with the console stalled
    for (int i = 0; i < 5; i++) wr(16'hF000, 8'h11 + 8'(i));
    rd(16'hF001, "status_ovf", 8'h45);
    tx_ready = 1'b1;
    repeat (5) idle();
    check_eq("tx_drained", 8'(tx_valid), 8'h00);
    tx_ready = 1'b0;
    wr(16'hF001, 8'h04);
    rd(16'hF001, "status_clr", 8'h02);

    // Push into a full FIFO on the same edge as a pop
    for (int i = 0; i < 4; i++) wr(16'hF000, 8'h21 + 8'(i));
    tx_ready = 1'b1;
    wr(16'hF000, 8'h25);
    tx_ready = 1'b0;
    rd(16'hF001, "status_full_pop", 8'h41);
    tx_ready = 1'b1;
    repeat (5) idle();
    tx_ready = 1'b0;
    rd(16'hF001, "status_empty", 8'h02);

    // RX capture holds off further bytes until read
    rx_data  = 8'hA7;
    rx_valid = 1'b1;
    idle();
    check_eq("rx_ready_low", 8'(rx_ready), 8'h00);
    idle();
    idle();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd(16'hF001, "status_rx", 8'h0A);
    rd(16'hF002, "rxdata", 8'hA7);
    check_eq("rx_ready_back", 8'(rx_ready), 8'h01);

    // Byte offered at the clearing edge waits one edge
    rx_data  = 8'hB3;
    rx_valid = 1'b1;
    idle();
    rx_data = 8'hC4;
    rd(16'hF002, "rx_b3", 8'hB3);
    check_eq("rx_not_cap", 8'(rx_ready), 8'h01);
    idle();
    check_eq("rx_cap_next", 8'(rx_ready), 8'h00);
    rx_valid = 1'b0;
    rd(16'hF002, "rx_c4", 8'hC4);

    // Reset in the middle of a write cycle
    wr(16'h0050, 8'h77);
    wr(16'hF000, 8'h66);
    @(negedge ph2);
    u_bus.address = 16'h0050;
    u_bus.wdata   = 8'h99;
    u_bus.read_en = 1'b0;
    #2 reset = 1'b0;
    @(posedge ph2);
    #3 reset = 1'b1;
    tx_q.delete();
    rd_q.delete();
    tag_q.delete();
    check_eq("mid_rst_rdata", u_bus.rdata, 8'h00);
    check_eq("mid_rst_tx_valid", 8'(tx_valid), 8'h00);
    rd(16'h0050, "ram_abort", 8'h77);

    // Cycle counter snapshot
    rd(16'hF003, "cyclo_early", m_cyc[7:0]);
    n = 0;
    while (m_cyc != 16'h00FF && n < 1000) begin
      idle();
      n++;
    end
    if (n >= 1000) check_eq("cyc_timeout", 8'(n >= 1000), 8'h00);
    rd(16'hF003, "cyclo_ff", 8'hFF);
    rd(16'hF004, "cychi_00", 8'h00);
    rd(16'hF003, "cyclo_101", 8'h01);
    rd(16'hF004, "cychi_01", 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
